// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the data memory controller
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic [3:0] be_t;

  // Little-endian lane mask for an aligned access; reserved size enables nothing.
  function automatic be_t lane_enables(input logic [1:0] size, input logic [1:0] off);
    be_t be;
    case (size)
      SZ_BYTE: be = be_t'(4'b0001 << off);
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with per-lane write enables
// Synchronous write, combinational read; contents are never reset.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  be_t           we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - single-outstanding load/store front end for dmem_array
// Decodes size/alignment/range, steers store lanes and extends load lanes.
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  state_e      state;
  logic [CW-1:0] cnt;

  logic        accept;
  logic        out_of_range;
  logic        misaligned;
  logic        bad_size;
  logic        err;
  be_t         we_lanes;
  logic [31:0] store_data;
  logic [31:0] rword;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;

  assign accept       = req_valid && req_ready;
  assign out_of_range = (req_addr[31:2] >= 30'(DEPTH));
  assign bad_size     = (req_size == 2'd3);
  assign misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign err          = bad_size || misaligned || out_of_range;

  assign we_lanes = (accept && req_we && !err) ? lane_enables(req_size, req_addr[1:0]) : '0;

  // Replicate right-aligned store data so every candidate lane carries it.
  always_comb begin
    store_data = req_wdata;
    case (req_size)
      SZ_BYTE: store_data = {4{req_wdata[7:0]}};
      SZ_HALF: store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (we_lanes),
    .addr  (req_addr[AW+1:2]),
    .wdata (store_data),
    .rdata (rword)
  );

  always_comb begin
    lane_byte = rword[7:0];
    case (req_addr[1:0])
      2'd0:    lane_byte = rword[7:0];
      2'd1:    lane_byte = rword[15:8];
      2'd2:    lane_byte = rword[23:16];
      default: lane_byte = rword[31:24];
    endcase
  end

  assign lane_half = req_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = '0;
    case (req_size)
      SZ_BYTE: load_val = {{24{req_signed & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_val = {{16{req_signed & lane_half[15]}}, lane_half};
      SZ_WORD: load_val = rword;
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready  <= 1'b0;
            resp_err   <= err;
            resp_rdata <= (err || req_we) ? 32'h0 : load_val;
            if (LATENCY == 1) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // Ready rises only after the handshake, so no back-to-back issue.
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl (LATENCY 1 and 4 instances)
module tb_dmem_ctrl;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        resetn     [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(1)) dut0 (
    .clk(clk), .resetn(resetn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(4)) dut1 (
    .clk(clk), .resetn(resetn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  // Byte-addressed reference memory per instance.
  logic [7:0] mdl [2][4*DEPTH];

  function automatic void model(input int s, input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
    int nb;
    longint v;
    nb = 1 << size;
    er = (size == 2'd3) || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
    rd = 32'h0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < nb; i++) mdl[s][addr + i] = wdata[8*i +: 8];
      return;
    end
    v = 0;
    for (int i = 0; i < nb; i++) v += longint'(mdl[s][addr + i]) << (8 * i);
    if (sgn && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
    rd = v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input int s, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input int rdly,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid[s] = 1'b1; req_we[s] = we; req_size[s] = size;
    req_signed[s] = sgn; req_addr[s] = addr; req_wdata[s] = wdata;
    n = 0;
    while (!req_ready[s] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[s]) chk("accept_timeout", 32'(req_ready[s]), 32'h1);
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid[s]) chk("ready_low_busy", 32'(req_ready[s]), 32'h0);
    end while (!resp_valid[s] && lat < 50);
    rd = resp_rdata[s];
    er = resp_err[s];
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid[s]), 32'h1);
      chk("stall_rdata", resp_rdata[s], rd);
      chk("stall_err", 32'(resp_err[s]), 32'(er));
      chk("stall_ready", 32'(req_ready[s]), 32'h0);
    end
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready[s] = 1'b0;
    @(negedge clk);
    chk("post_hs_ready", 32'(req_ready[s]), 32'h1);
    chk("post_hs_valid", 32'(resp_valid[s]), 32'h0);
  endtask

  task automatic check_txn(input int s, input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input int rdly,
                           input logic [31:0] erd, input logic eer, input string tag);
    logic [31:0] rd;
    logic er;
    int lat;
    txn(s, we, size, sgn, addr, wdata, rdly, rd, er, lat);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, 32'(er), 32'(eer));
    chk({tag, "_lat"}, 32'(lat), (s == 0) ? 32'd1 : 32'd4);
  endtask

  task automatic run(input int s, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input int rdly,
                     input string tag);
    logic [31:0] erd;
    logic eer;
    model(s, we, size, sgn, addr, wdata, erd, eer);
    check_txn(s, we, size, sgn, addr, wdata, rdly, erd, eer, tag);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [31:0] erd;
    logic eer;
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int acc, rsp, last, cyc;
    bit took;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h13,  32'h00000080, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'h00000080, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h00,  32'h11111111, 32'h0,        1'b0};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADDEAD, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h00,  32'h0,        32'h11111111, 1'b0};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h12,  32'hFFFF1234, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1234BEEF, 1'b0};
    tbl[13] = '{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1};
    tbl[15] = '{1'b1, 2'd2, 1'b0, 32'hFC,  32'hA5A50001, 32'h0,        1'b0};
    tbl[16] = '{1'b0, 2'd0, 1'b1, 32'hFF,  32'h0,        32'hFFFFFFA5, 1'b0};
    tbl[17] = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        32'h0,        1'b1};

    for (int s = 0; s < 2; s++) begin
      resetn[s] = 1'b0; req_valid[s] = 1'b0; req_we[s] = 1'b0; req_size[s] = 2'd0;
      req_signed[s] = 1'b0; req_addr[s] = 32'h0; req_wdata[s] = 32'h0; resp_ready[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", 32'(resp_valid[s]), 32'h0);
      chk("rst_rdata", resp_rdata[s], 32'h0);
      chk("rst_err", 32'(resp_err[s]), 32'h0);
      resetn[s] = 1'b1;
    end
    @(negedge clk);
    for (int s = 0; s < 2; s++) chk("rst_ready", 32'(req_ready[s]), 32'h1);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) run(s, 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, 0, "init");

    for (int i = 0; i < 18; i++) begin
      model(0, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, erd, eer);
      check_txn(0, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, i % 3,
                tbl[i].rd, tbl[i].er, "tbl");
    end

    // Long latency with a 3-cycle consumer stall.
    run(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 0, "l4_store");
    run(1, 1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 3, "l4_stall");

    // Reset while in WAIT after a store: store persists, response is dropped.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2;
    req_signed[1] = 1'b0; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    model(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, erd, eer);
    @(negedge clk);
    chk("wait_ready", 32'(req_ready[1]), 32'h0);
    resetn[1] = 1'b0;
    #1;
    chk("midrst_valid", 32'(resp_valid[1]), 32'h0);
    repeat (2) @(negedge clk);
    resetn[1] = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready[1]), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_novalid", 32'(resp_valid[1]), 32'h0);
    end
    check_txn(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 32'h12345678, 1'b0, "midrst_load");

    // Back-to-back requests with req_valid held high throughout.
    acc = 0; rsp = 0; last = -100; cyc = 0;
    resp_ready[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2; req_signed[1] = 1'b0;
    req_addr[1] = 32'h0; req_wdata[1] = 32'h0;
    while ((acc < 5 || rsp < 5) && cyc < 200) begin
      if (resp_valid[1]) begin
        rsp++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        chk("burst_rdata", resp_rdata[1], e);
      end
      took = req_valid[1] && req_ready[1];
      if (took) begin
        chk("burst_accept_idle", 32'(resp_valid[1]), 32'h0);
        if (acc > 0) chk("burst_gap", 32'(cyc - last >= 5), 32'h1);
        last = cyc;
        model(1, 1'b0, 2'd2, 1'b0, req_addr[1], 32'h0, erd, eer);
        exp_q.push_back(erd);
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        if (acc < 5) req_addr[1] = 32'(4 * acc);
        else req_valid[1] = 1'b0;
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    chk("burst_acc", 32'(acc), 32'd5);
    chk("burst_rsp", 32'(rsp), 32'd5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("burst_no_extra", 32'(resp_valid[1]), 32'h0);
    end
    resp_ready[1] = 1'b0;

    // Randomised traffic against the reference model, including errors.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 60; i++) begin
        int r;
        r = $urandom_range(0, 9);
        run(s, 1'($urandom_range(0, 1)), (r < 9) ? 2'(r % 3) : 2'd3, 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 4 * DEPTH + 15)), $urandom, $urandom_range(0, 2), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words; SHALL be a power of two, at least 4.
REQ-002 Parameter LATENCY, default 1, cycles from request acceptance to resp_valid; SHALL be at least 1.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 Port req_valid  in  1  request present.
REQ-006 Port req_ready  out  1  block can accept a request.
REQ-007 Port req_we  in  1  1 = store, 0 = load.
REQ-008 Port req_size  in  2  access size: byte, half or word; encoding 3 is reserved.
REQ-009 Port req_signed  in  1  load sign-extends when 1 and zero-extends when 0.
REQ-010 Port req_addr  in  32  byte address.
REQ-011 Port req_wdata  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
REQ-012 Port resp_valid  out  1  response present.
REQ-013 Port resp_ready  in  1  consumer accepts the response.
REQ-014 Port resp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-015 Port resp_err  out  1  request was misaligned, out of range or used a reserved size.

Function
REQ-016 The block SHALL have FSM states IDLE, WAIT and RESP, with at most one request outstanding.
REQ-017 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-018 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-019 On acceptance, the next state SHALL be RESP if LATENCY is 1, otherwise WAIT with the counter loaded to LATENCY-2.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter is 0.
REQ-021 resp_valid SHALL be 1 exactly while in RESP, so that it first rises LATENCY cycles after the acceptance edge.
REQ-022 In RESP, an edge with resp_ready=1 SHALL return the FSM to IDLE; otherwise resp_valid, resp_rdata and resp_err SHALL hold stable.
REQ-023 A request SHALL NOT be accepted on the same edge that completes a response; this gives a minimum issue interval of LATENCY+1 cycles.
REQ-024 word index = req_addr[31:2]; an index at or above DEPTH SHALL be out of range.
REQ-025 Misaligned SHALL mean a half access with addr[0]=1, or a word access with addr[1:0] nonzero.
REQ-026 An errored request SHALL produce no memory write, resp_err=1 and resp_rdata=0.
REQ-027 A valid store SHALL write the array on the acceptance edge.
REQ-028 A store SHALL enable only the addressed lanes: byte uses lane addr[1:0]; half uses lanes addr[1]*2 and addr[1]*2+1; word uses all four lanes.
REQ-029 A valid load SHALL sample the array on the acceptance edge and register the selected lane(s), extended per req_signed.
REQ-030 A load accepted after a store has completed SHALL observe that store's data.
REQ-031 Lane numbering SHALL be little-endian: lane 0 = bits [7:0].

Reset
REQ-032 While resetn=0, the block SHALL force the FSM to IDLE, the counter to 0, resp_valid=0, resp_rdata=0 and resp_err=0, with req_ready=1 after release.
REQ-033 Reset mid-operation SHALL discard any pending response; a store already accepted SHALL remain written.
REQ-034 Array contents SHALL NOT be reset and are undefined until written.

Structure
REQ-035 A shared package mem_pkg SHALL hold the access-size enum (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), the FSM state enum and a byte-enable typedef (4 bits).
REQ-036 Storage SHALL be a sub-module dmem_array: DEPTH words, 4 byte-lane write enables, synchronous write, combinational read.
REQ-037 Lane select, extension and error checks SHALL be in dmem_ctrl.

Verification
REQ-038 Default parameters: store word 0xDEADBEEF at 0x10, then load word 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, and resp_valid 1 cycle after acceptance.
REQ-039 Store byte 0x80 at 0x13, then load byte at 0x13 with req_signed=1 -> 0xFFFFFF80; with req_signed=0 -> 0x00000080; the word at 0x10 reads 0x80ADBEEF.
REQ-040 Load half at 0x11 -> resp_err=1, resp_rdata=0; store word at 0x100 with DEPTH=64 -> resp_err=1 and memory unchanged.
REQ-041 LATENCY=4: hold resp_ready=0 for 3 cycles -> resp_valid rises 4 cycles after acceptance, outputs stay stable, and req_ready stays 0 until 1 cycle after the resp_ready handshake.
REQ-042 LATENCY=4: assert resetn=0 in WAIT after a store of 0x12345678 to 0x20 -> no resp_valid, req_ready=1 after release, and a later load of 0x20 returns 0x12345678.
REQ-043 Hold req_valid=1 continuously over 5 requests -> each response appears once, and there are no acceptances while the FSM is in WAIT or RESP.
